// File: rtl/counter_pkg.sv
// Shared encodings for the modulo up/down/bounce counter family.
package counter_pkg;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mod_next_state.sv
// Combinational step function of the modulo counter: next count, next direction
// and the end-of-range flag used for terminal count.
module mod_next_state
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q_next,
    output logic             dir_next,
    output logic             end_flag
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);

    always_comb begin
        q_next   = q;
        dir_next = dir;
        end_flag = 1'b0;
        case (mode)
            MODE_UP: begin
                dir_next = DIR_UP;
                if (q == MAX_Q) begin
                    q_next   = '0;
                    end_flag = 1'b1;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                dir_next = DIR_DOWN;
                if (q == '0) begin
                    q_next   = MAX_Q;
                    end_flag = 1'b1;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
            MODE_BOUNCE: begin
                // Turnaround steps away from the endpoint so it is never repeated.
                if (dir == DIR_UP) begin
                    if (q == MAX_Q) begin
                        q_next   = q - WIDTH'(1);
                        dir_next = DIR_DOWN;
                        end_flag = 1'b1;
                    end else begin
                        q_next = q + WIDTH'(1);
                    end
                end else begin
                    if (q == '0) begin
                        q_next   = q + WIDTH'(1);
                        dir_next = DIR_UP;
                        end_flag = 1'b1;
                    end else begin
                        q_next = q - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// WIDTH-bit modulo-MOD counter with parallel load, up/down/hold/bounce modes,
// cascadable terminal count and a sticky illegal-load flag.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] Q,
    output logic             DIR,
    output logic             TC,
    output logic             LOAD_ERR
);

    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] q_next;
    logic             dir_next;
    logic             end_flag;
    logic             d_legal;

    mod_next_state #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next (
        .q        (Q),
        .dir      (DIR),
        .mode     (MODE),
        .q_next   (q_next),
        .dir_next (dir_next),
        .end_flag (end_flag)
    );

    // Extra bit keeps the compare valid when MOD == 2**WIDTH.
    assign d_legal = {1'b0, D} < MOD_EXT;

    assign TC = EN & ~LOAD & ~RESET & end_flag;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            Q        <= '0;
            DIR      <= DIR_UP;
            LOAD_ERR <= 1'b0;
        end else if (LOAD) begin
            if (d_legal) begin
                Q        <= D;
                LOAD_ERR <= 1'b0;
            end else begin
                Q        <= MAX_Q;
                LOAD_ERR <= 1'b1;
                if (MODE == MODE_BOUNCE) begin
                    DIR <= DIR_DOWN;
                end
            end
        end else if (EN) begin
            Q   <= q_next;
            DIR <= dir_next;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: MOD=10 and MOD=4 counters against an arithmetic model,
// plus a two-digit decimal cascade against a binary-to-BCD reference.
module tb_mod_updown_counter;
    import counter_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned MA = 10;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, ld, en;
    logic [W-1:0] d;
    logic [1:0]   mode;
    logic [W-1:0] q_a, q_b;
    logic         dir_a, dir_b, tc_a, tc_b, err_a, err_b;

    logic         cas_rst, cas_en, cas_ld;
    logic [W-1:0] cas_d;
    logic [1:0]   cas_mode;
    logic [W-1:0] q_ones, q_tens;
    logic         dir_ones, dir_tens, tc_ones, tc_tens, err_ones, err_tens;

    int total = 0;
    int bad   = 0;

    int ma_q = 0, mb_q = 0;
    bit ma_dir = 1'b0, mb_dir = 1'b0, ma_err = 1'b0, mb_err = 1'b0;

    int up_exp[12]    = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int down_exp[3]   = '{0, 9, 8};
    int bounce_exp[8] = '{1, 2, 3, 2, 1, 0, 1, 2};

    mod_updown_counter #(.WIDTH(W), .MOD(MA)) dut_a (
        .CLOCK_50(clk), .RESET(rst), .EN(en), .LOAD(ld), .D(d), .MODE(mode),
        .Q(q_a), .DIR(dir_a), .TC(tc_a), .LOAD_ERR(err_a)
    );

    mod_updown_counter #(.WIDTH(W), .MOD(MB)) dut_b (
        .CLOCK_50(clk), .RESET(rst), .EN(en), .LOAD(ld), .D(d), .MODE(mode),
        .Q(q_b), .DIR(dir_b), .TC(tc_b), .LOAD_ERR(err_b)
    );

    mod_updown_counter #(.WIDTH(W), .MOD(MA)) dut_ones (
        .CLOCK_50(clk), .RESET(cas_rst), .EN(cas_en), .LOAD(cas_ld), .D(cas_d),
        .MODE(cas_mode), .Q(q_ones), .DIR(dir_ones), .TC(tc_ones), .LOAD_ERR(err_ones)
    );

    mod_updown_counter #(.WIDTH(W), .MOD(MA)) dut_tens (
        .CLOCK_50(clk), .RESET(cas_rst), .EN(tc_ones), .LOAD(cas_ld), .D(cas_d),
        .MODE(cas_mode), .Q(q_tens), .DIR(dir_tens), .TC(tc_tens), .LOAD_ERR(err_tens)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: priority reset > load > enable, modular arithmetic.
    task automatic ref_step(input int m, input bit r, input bit l, input bit e,
                            input int dv, input int md,
                            inout int q, inout bit dir, inout bit err, output bit tc);
        tc = 1'b0;
        if (r) begin
            q = 0; dir = 1'b0; err = 1'b0;
        end else if (l) begin
            if (dv < m) begin
                q = dv; err = 1'b0;
            end else begin
                q = m - 1; err = 1'b1;
                if (md == 3) dir = 1'b1;
            end
        end else if (e) begin
            case (md)
                0: begin tc = (q == m - 1); q = (q + 1) % m; dir = 1'b0; end
                1: begin tc = (q == 0); q = (q + m - 1) % m; dir = 1'b1; end
                3: begin
                    if (!dir) begin
                        if (q == m - 1) begin tc = 1'b1; q = q - 1; dir = 1'b1; end
                        else q = q + 1;
                    end else begin
                        if (q == 0) begin tc = 1'b1; q = q + 1; dir = 1'b0; end
                        else q = q - 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock with shared inputs to both standalone counters.
    task automatic cyc(input bit r, input bit l, input bit e, input int dv, input int md);
        int qa, qb;
        bit da, db, ea, eb, ta, tb;
        rst = r; ld = l; en = e; d = W'(dv); mode = 2'(md);
        qa = ma_q; da = ma_dir; ea = ma_err;
        qb = mb_q; db = mb_dir; eb = mb_err;
        ref_step(MA, r, l, e, dv, md, qa, da, ea, ta);
        ref_step(MB, r, l, e, dv, md, qb, db, eb, tb);
        @(negedge clk);
        check("tc_a", int'(tc_a), int'(ta));
        check("tc_b", int'(tc_b), int'(tb));
        @(posedge clk);
        #1;
        ma_q = qa; ma_dir = da; ma_err = ea;
        mb_q = qb; mb_dir = db; mb_err = eb;
        check("q_a", int'(q_a), ma_q);
        check("dir_a", int'(dir_a), int'(ma_dir));
        check("err_a", int'(err_a), int'(ma_err));
        check("q_b", int'(q_b), mb_q);
        check("dir_b", int'(dir_b), int'(mb_dir));
        check("err_b", int'(err_b), int'(mb_err));
    endtask

    initial begin
        int pulses;
        cas_rst = 1'b1; cas_en = 1'b0; cas_ld = 1'b0; cas_d = '0; cas_mode = MODE_UP;

        cyc(1, 0, 0, 0, 0);
        check("rst_q", int'(q_a), 0);
        check("rst_err", int'(err_a), 0);

        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("up_seq", int'(q_a), up_exp[i]);
        end

        cyc(0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 1);
            check("down_seq", int'(q_a), down_exp[i]);
        end
        check("down_dir", int'(dir_a), 1);

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 3);
            check("bounce_seq", int'(q_b), bounce_exp[i]);
        end

        cyc(0, 1, 0, 12, 0);
        check("bad_load_q", int'(q_a), 9);
        check("bad_load_err", int'(err_a), 1);
        cyc(0, 1, 0, 5, 0);
        check("good_load_q", int'(q_a), 5);
        check("good_load_err", int'(err_a), 0);

        cyc(0, 1, 0, 7, 0);
        cyc(1, 1, 1, 7, 0);
        check("prio_rst", int'(q_a), 0);
        cyc(0, 1, 1, 3, 0);
        check("prio_load", int'(q_a), 3);
        cyc(0, 0, 0, 0, 0);
        check("en_off", int'(q_a), 3);
        cyc(0, 0, 1, 0, 2);
        check("hold_mode", int'(q_a), 3);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 32) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        // Two-digit decimal cascade from reset.
        @(negedge clk);
        cas_rst = 1'b1; cas_en = 1'b0;
        @(posedge clk); #1;
        cas_rst = 1'b0;
        check("cas_rst", int'(q_tens) * 10 + int'(q_ones), 0);
        pulses = 0;
        for (int n = 0; n < 100; n++) begin
            cas_en = 1'b1;
            @(negedge clk);
            check("ones_tc", int'(tc_ones), int'((n % 10) == 9));
            check("tens_tc", int'(tc_tens), int'(n == 99));
            if (tc_tens) pulses++;
            @(posedge clk); #1;
            check("bcd_ones", int'(q_ones), ((n + 1) % 100) % 10);
            check("bcd_tens", int'(q_tens), ((n + 1) % 100) / 10);
        end
        cas_en = 1'b0;
        check("tens_pulses", pulses, 1);
        check("cas_dir", int'(dir_ones) + int'(dir_tens), 0);
        check("cas_err", int'(err_ones) + int'(err_tens), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the team's 4-bit loadable counter: WIDTH-bit modulo-MOD counter with synchronous parallel load.
- Modes: up, down, hold and bounce (ping-pong).
- Provides terminal-count output for cascading digits, plus sticky load-error flag.
- Drives the binary_to_BCD / hex_7seg display path on the board top level.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 10, modulus; legal count range 0..MOD-1; constraint 2 <= MOD <= 2**WIDTH.

Ports:
- CLOCK_50 input 1: sole clock, rising edge.
- RESET input 1: synchronous, active-high reset.
- EN input 1: count enable; also acts as cascade-in from the less significant digit's TC.
- LOAD input 1: synchronous parallel load, active-high.
- D input WIDTH: load value.
- MODE input 2: 00 up, 01 down, 10 hold, 11 bounce.
- Q output WIDTH: registered count.
- DIR output 1: registered direction, 0 = up, 1 = down; meaningful in bounce, otherwise mirrors mode.
- TC output 1: combinational terminal count.
- LOAD_ERR output 1: sticky, registered.

Behaviour:
- Priority per rising edge: RESET > LOAD > EN > hold.
- RESET: Q=0, DIR=0, LOAD_ERR=0.
- LOAD with D < MOD: Q=D, LOAD_ERR=0, DIR unchanged.
- LOAD with D >= MOD:
  - Q=MOD-1, LOAD_ERR=1.
  - In bounce mode DIR=1, so the next step moves downward.
- LOAD_ERR stays set until RESET or a legal LOAD.
- EN=1, MODE=00: Q = (Q==MOD-1) ? 0 : Q+1; DIR=0.
- EN=1, MODE=01: Q = (Q==0) ? MOD-1 : Q-1; DIR=1.
- EN=1, MODE=10: Q and DIR held.
- EN=1, MODE=11 (bounce):
  - DIR=0 and Q<MOD-1: Q+1.
  - DIR=0 and Q==MOD-1: Q-1, DIR=1.
  - DIR=1 and Q>0: Q-1.
  - DIR=1 and Q==0: Q+1, DIR=0.
  - Endpoint values are never repeated.
- EN=0: Q and DIR held regardless of MODE.
- TC = EN & ~LOAD & ~RESET & (end condition):
  - up: Q==MOD-1.
  - down: Q==0.
  - bounce: Q==MOD-1 with DIR=0, or Q==0 with DIR=1.
  - hold: 0.
- TC is a same-cycle pulse: it asserts in the cycle whose edge performs the wrap or turnaround. Chaining TC to the next digit's EN yields a ripple-free synchronous cascade.
- MODE change mid-count:
  - Takes effect on the next enabled edge.
  - Switching into bounce keeps the current DIR (up→0, down→1).
- Arithmetic is on WIDTH bits and never exceeds MOD-1, so no overflow can occur. Q values outside 0..MOD-1 are unreachable after RESET.
- Latency: 1 cycle from edge to Q. TC follows Q/EN/MODE combinationally with no register stage.
- No initial blocks are used; state is defined only through RESET.

Decomposition:
- Shared package counter_pkg holds:
  - mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_HOLD=2'b10, MODE_BOUNCE=2'b11;
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
- One natural sub-module, mod_next_state: purely combinational (Q, DIR, MODE) -> (Q_next, DIR_next, end_flag), parameterised on WIDTH/MOD.
  - The top contains only registers, priority muxing, the LOAD_ERR flag and TC gating.

Test Plan:
- Reset and up wrap: RESET 1 cycle, MODE=00, EN=1 for 12 cycles -> Q 1..9,0,1,2. TC=1 only while Q=9. DIR=0, LOAD_ERR=0.
- Down wrap: LOAD D=1, then MODE=01, EN=1 -> Q 0,9,8. TC=1 while Q=0. DIR=1.
- Bounce, WIDTH=4, MOD=4: from reset, MODE=11, EN=1 for 8 cycles -> Q 1,2,3,2,1,0,1,2. TC high at Q=3 (DIR=0) and Q=0 (DIR=1).
- Illegal load: D=12 with MOD=10 -> Q=9, LOAD_ERR=1. Next LOAD D=5 -> Q=5, LOAD_ERR=0.
- Priority and hold: RESET, LOAD and EN all high with Q=7 -> Q=0. LOAD and EN high with D=3 -> Q=3, TC=0. EN=0 with MODE=00 -> Q stays 3. MODE=10 with EN=1 -> Q stays 3, TC=0.
- Cascade of two instances (ones TC -> tens EN), MODE=00, 100 enabled cycles from reset:
  - tens:ones sequence 00..99 then 00.
  - Tens TC pulses exactly once, at 99.
  - Output matches the binary_to_BCD reference model.
